// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS controller
// Purpose: state enum, opcode/funct constants, ALU codes, datapath select
//          encodings and the registered control-word type.
// Ports:   none (package).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXEC = 4'd7,
    S_RTWB   = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_JAL    = 4'd13,
    S_JR     = 4'd14,
    S_HALT   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [4:0] alu_op;
    logic       halted;
  } ctrl_t;

  // States in which an instruction completes.
  function automatic logic is_retire(state_e s);
    return s inside {S_MEMWB, S_MEMWR, S_RTWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR};
  endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// rtl/mips_mc_controller_if.sv - controller/datapath signal bundle
// Purpose: groups instruction fields, ALU flag and all control outputs.
// Ports:   master = controller (drives strobes/selects/status),
//          slave  = datapath (drives run/opcode/funct/zero).
interface mips_mc_controller_if;
  logic        run;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        pcWrite;
  logic        pcWriteCond;
  logic        iorD;
  logic        memRead;
  logic        memWrite;
  logic        irWrite;
  logic        regWrite;
  logic        aluSrcA;
  logic [1:0]  regDst;
  logic [1:0]  wbSel;
  logic [1:0]  aluSrcB;
  logic [1:0]  pcSrc;
  logic [4:0]  aluOperation;
  logic        halted;
  logic [31:0] retired;
  logic [3:0]  state;

  modport master (
    input  run, opcode, funct, zero,
    output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, regWrite,
           aluSrcA, regDst, wbSel, aluSrcB, pcSrc, aluOperation, halted,
           retired, state
  );

  modport slave (
    output run, opcode, funct, zero,
    input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, regWrite,
           aluSrcA, regDst, wbSel, aluSrcB, pcSrc, aluOperation, halted,
           retired, state
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - R-type funct to ALU operation decode
// Purpose: combinational map of funct to ALU code; valid=0 for unsupported funct.
// Ports:   funct (in, 6), alu_op (out, 5), valid (out, 1).
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [4:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS control FSM with retire counter
// Purpose: sequences fetch/decode/execute/writeback and counts retired
//          instructions; traps illegal opcodes/functs into HALT.
// Ports:   clk (in), rst (in, async active-low),
//          bus (mips_mc_controller_if.master: run/opcode/funct/zero in,
//          strobes, selects, halted, retired, state out).
module mips_mc_controller
  import mips_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mips_mc_controller_if.master bus
);

  state_e      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] retired_q, retired_d;

  logic [4:0]  rt_alu_op;
  logic        rt_funct_ok;

  // The branch condition is applied in the datapath; the flag is carried on
  // the bundle but not consumed here.
  logic unused_zero;
  assign unused_zero = bus.zero;

  mips_alu_decoder u_alu_dec (
    .funct  (bus.funct),
    .alu_op (rt_alu_op),
    .valid  (rt_funct_ok)
  );

  // Outputs are registered from the next-state decode, so the reset clears
  // them immediately and they never glitch on input changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retired_d = retired_q + (is_retire(state_q) ? 32'd1 : 32'd0);
    case (state_q)
      S_IDLE:   state_d = bus.run ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:        state_d = (bus.funct == FN_JR) ? S_JR : S_RTEXEC;
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_IEXEC;
          OP_J:            state_d = S_JUMP;
          OP_JAL:          state_d = S_JAL;
          default:         state_d = S_HALT;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_RTEXEC: state_d = rt_funct_ok ? S_RTWB : S_HALT;
      S_IEXEC:  state_d = S_IWB;
      S_HALT:   state_d = S_HALT;
      // Every remaining state retires; run is only sampled here and in IDLE.
      default:  state_d = bus.run ? S_FETCH : S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.ir_write  = 1'b1;
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
        ctrl_d.pc_src    = PCSRC_ALU;
        ctrl_d.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        ctrl_d.alu_src_b = SRCB_IMMSH;
        ctrl_d.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = REGDST_RT;
        ctrl_d.wb_sel    = WB_MDR;
      end
      S_MEMWR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.ior_d     = 1'b1;
      end
      S_RTEXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_B;
        ctrl_d.alu_op    = rt_alu_op;
      end
      S_RTWB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = REGDST_RD;
        ctrl_d.wb_sel    = WB_ALUOUT;
      end
      S_IEXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_op    = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IWB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = REGDST_RT;
        ctrl_d.wb_sel    = WB_ALUOUT;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_src_b     = SRCB_B;
        ctrl_d.alu_op        = ALU_SUB;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_src        = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_d.pc_write = 1'b1;
        ctrl_d.pc_src   = PCSRC_JUMP;
      end
      S_JAL: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_src    = PCSRC_JUMP;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = REGDST_R31;
        ctrl_d.wb_sel    = WB_PC;
      end
      S_JR: begin
        ctrl_d.pc_write = 1'b1;
        ctrl_d.pc_src   = PCSRC_RS;
      end
      S_HALT:  ctrl_d.halted = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  assign bus.pcWrite      = ctrl_q.pc_write;
  assign bus.pcWriteCond  = ctrl_q.pc_write_cond;
  assign bus.iorD         = ctrl_q.ior_d;
  assign bus.memRead      = ctrl_q.mem_read;
  assign bus.memWrite     = ctrl_q.mem_write;
  assign bus.irWrite      = ctrl_q.ir_write;
  assign bus.regWrite     = ctrl_q.reg_write;
  assign bus.aluSrcA      = ctrl_q.alu_src_a;
  assign bus.regDst       = ctrl_q.reg_dst;
  assign bus.wbSel        = ctrl_q.wb_sel;
  assign bus.aluSrcB      = ctrl_q.alu_src_b;
  assign bus.pcSrc        = ctrl_q.pc_src;
  assign bus.aluOperation = ctrl_q.alu_op;
  assign bus.halted       = ctrl_q.halted;
  assign bus.retired      = retired_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - scoreboard bench for mips_mc_controller
module tb_mips_mc_controller;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_mc_controller_if bus ();

  mips_mc_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    state_e      st;
    logic [4:0]  alu;
    bit          ac;
    logic [31:0] ret;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [21:0] act_ctl;
  assign act_ctl = {bus.pcWrite, bus.pcWriteCond, bus.iorD, bus.memRead,
                    bus.memWrite, bus.irWrite, bus.regWrite, bus.aluSrcA,
                    bus.regDst, bus.wbSel, bus.aluSrcB, bus.pcSrc,
                    bus.aluOperation, bus.halted};

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected control word per state, written out from the output table.
  function automatic logic [21:0] exp_ctl(state_e s, logic [4:0] alu);
    logic pw, pwc, iod, mr, mw, irw, rw, sa, h;
    logic [1:0] rd, wb, sb, ps;
    logic [4:0] op;
    {pw, pwc, iod, mr, mw, irw, rw, sa, h} = '0;
    {rd, wb, sb, ps} = '0;
    op = 5'd0;
    case (s)
      S_FETCH:  begin pw = 1; mr = 1; irw = 1; sb = 2'd1; end
      S_DECODE: sb = 2'd3;
      S_MEMADR: begin sa = 1; sb = 2'd2; end
      S_MEMRD:  begin mr = 1; iod = 1; end
      S_MEMWB:  begin rw = 1; wb = 2'd1; end
      S_MEMWR:  begin mw = 1; iod = 1; end
      S_RTEXEC: begin sa = 1; op = alu; end
      S_RTWB:   begin rw = 1; rd = 2'd1; end
      S_IEXEC:  begin sa = 1; sb = 2'd2; op = alu; end
      S_IWB:    rw = 1;
      S_BRANCH: begin sa = 1; op = 5'd1; pwc = 1; ps = 2'd1; end
      S_JUMP:   begin pw = 1; ps = 2'd2; end
      S_JAL:    begin pw = 1; ps = 2'd2; rw = 1; rd = 2'd2; wb = 2'd2; end
      S_JR:     begin pw = 1; ps = 2'd3; end
      S_HALT:   h = 1;
      default:  ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, rw, sa, rd, wb, sb, ps, op, h};
  endfunction

  // Monitor: one expectation per clock, compared mid-cycle.
  initial begin
    exp_t e;
    logic [21:0] a, x;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = act_ctl;
        x = exp_ctl(e.st, e.alu);
        if (!e.ac) begin
          a[5:1] = 5'd0;
          x[5:1] = 5'd0;
        end
        chk($sformatf("state@%0d", cyc), 32'(bus.state), 32'(e.st));
        chk($sformatf("ctl@%0d st=%0d", cyc, e.st), 32'(a), 32'(x));
        chk($sformatf("retired@%0d", cyc), bus.retired, e.ret);
      end
    end
  end

  task automatic tick(state_e st, logic [4:0] alu, logic [31:0] ret, bit ac = 1'b1);
    exp_t e;
    @(posedge clk);
    e.st = st; e.alu = alu; e.ac = ac; e.ret = ret;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic async_reset_check(string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_state"}, 32'(bus.state), 32'(S_IDLE));
    chk({tag, "_retired"}, bus.retired, 32'd0);
    chk({tag, "_ctl"}, 32'(act_ctl), 32'd0);
  endtask

  logic [5:0] rfn[5];
  logic [4:0] ralu[5];
  int r;

  initial begin
    rfn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ralu = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4};
    bus.run = 1'b0; bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
    rst = 1'b1;
    #1;
    async_reset_check("reset");
    @(negedge clk); #1;
    bus.run = 1'b1;
    tick(S_IDLE, 0, 0);
    rst = 1'b1; bus.run = 1'b0;
    tick(S_IDLE, 0, 0); tick(S_IDLE, 0, 0);

    // lw: 5-cycle path, regWrite only in MEMWB
    bus.run = 1'b1; bus.opcode = 6'b100011;
    tick(S_FETCH, 0, 0); tick(S_DECODE, 0, 0); tick(S_MEMADR, 0, 0);
    tick(S_MEMRD, 0, 0); tick(S_MEMWB, 0, 0);
    bus.run = 1'b0;
    tick(S_IDLE, 0, 1);

    // beq taken then not taken, back to back
    bus.run = 1'b1; bus.opcode = 6'b000100; bus.zero = 1'b1;
    tick(S_FETCH, 0, 1); tick(S_DECODE, 0, 1); tick(S_BRANCH, 0, 1);
    bus.zero = 1'b0;
    tick(S_FETCH, 0, 2); tick(S_DECODE, 0, 2); tick(S_BRANCH, 0, 2);
    bus.run = 1'b0;
    tick(S_IDLE, 0, 3);

    // jal
    bus.run = 1'b1; bus.opcode = 6'b000011;
    tick(S_FETCH, 0, 3); tick(S_DECODE, 0, 3); tick(S_JAL, 0, 3);
    bus.run = 1'b0;
    tick(S_IDLE, 0, 4);

    // sw
    bus.run = 1'b1; bus.opcode = 6'b101011;
    tick(S_FETCH, 0, 4); tick(S_DECODE, 0, 4); tick(S_MEMADR, 0, 4); tick(S_MEMWR, 0, 4);
    bus.run = 1'b0;
    tick(S_IDLE, 0, 5);

    // addi, slti, j, jr chained with run held high
    bus.run = 1'b1; bus.opcode = 6'b001000;
    tick(S_FETCH, 0, 5); tick(S_DECODE, 0, 5); tick(S_IEXEC, 5'd0, 5); tick(S_IWB, 0, 5);
    bus.opcode = 6'b001010;
    tick(S_FETCH, 0, 6); tick(S_DECODE, 0, 6); tick(S_IEXEC, 5'd4, 6); tick(S_IWB, 0, 6);
    bus.opcode = 6'b000010;
    tick(S_FETCH, 0, 7); tick(S_DECODE, 0, 7); tick(S_JUMP, 0, 7);
    bus.opcode = 6'b000000; bus.funct = 6'b001000;
    tick(S_FETCH, 0, 8); tick(S_DECODE, 0, 8); tick(S_JR, 0, 8);

    // R-types; run drops during the last RTEXEC
    r = 9;
    for (int i = 0; i < 5; i++) begin
      bus.funct = rfn[i];
      tick(S_FETCH, 0, r); tick(S_DECODE, 0, r); tick(S_RTEXEC, ralu[i], r);
      if (i == 4) bus.run = 1'b0;
      tick(S_RTWB, 0, r);
      r++;
    end
    tick(S_IDLE, 0, 14);
    repeat (3) tick(S_IDLE, 0, 14);
    bus.run = 1'b1;

    // reset while in MEMRD
    bus.opcode = 6'b100011;
    tick(S_FETCH, 0, 14); tick(S_DECODE, 0, 14); tick(S_MEMADR, 0, 14); tick(S_MEMRD, 0, 14);
    async_reset_check("rst_memrd");
    tick(S_IDLE, 0, 0);
    rst = 1'b1; bus.run = 1'b0;
    tick(S_IDLE, 0, 0);

    // illegal opcode trap
    bus.run = 1'b1; bus.opcode = 6'b000010;
    tick(S_FETCH, 0, 0); tick(S_DECODE, 0, 0); tick(S_JUMP, 0, 0);
    bus.opcode = 6'b111111;
    tick(S_FETCH, 0, 1); tick(S_DECODE, 0, 1);
    repeat (21) tick(S_HALT, 0, 1);

    // illegal funct trap
    async_reset_check("rst_halt");
    tick(S_IDLE, 0, 0);
    rst = 1'b1; bus.opcode = 6'b000010;
    tick(S_FETCH, 0, 0); tick(S_DECODE, 0, 0); tick(S_JUMP, 0, 0);
    bus.opcode = 6'b000000; bus.funct = 6'b000001;
    tick(S_FETCH, 0, 1); tick(S_DECODE, 0, 1); tick(S_RTEXEC, 0, 1, 1'b0);
    repeat (21) tick(S_HALT, 0, 1);

    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
